// File: rtl/fp_bucket_index.sv
// fp_bucket_index: sequential IEEE-754 single-precision bucketiser.
// Compares one input against a runtime-loadable threshold table, one entry
// per cycle. It returns the address of the first threshold strictly greater
// than the input, or NUM_THRESH when no threshold is greater.
// NaN inputs return index 0 and set out_nan. NaN thresholds are skipped.
module fp_bucket_index #(
    parameter int NUM_THRESH = 15,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             thr_we,
    input  logic [IDX_W-1:0] thr_addr,
    input  logic [31:0]      thr_data,
    output logic             thr_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_nan
);

    localparam logic [31:0]      POS_INF  = 32'h7F80_0000;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_THRESH - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // A value is NaN when the exponent is all ones and the mantissa is non-zero.
    function automatic logic is_nan(input logic [30:0] mag);
        return (mag[30:23] == 8'hFF) && (mag[22:0] != 23'd0);
    endfunction

    // Map a float to an unsigned key whose integer order matches the float order.
    // -0 is folded onto +0 first so that the two zeros compare equal.
    function automatic logic [31:0] order_key(input logic [31:0] f);
        logic [31:0] c;
        c = (f[30:0] == 31'd0) ? 32'd0 : f;
        return c[31] ? ~c : (c ^ 32'h8000_0000);
    endfunction

    // True when threshold t is strictly greater than x. A NaN threshold never is.
    function automatic logic thr_greater(input logic [31:0] x, input logic [31:0] t);
        return !is_nan(t[30:0]) && (order_key(x) < order_key(t));
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             nan_q, nan_d;
    logic [31:0]      x_q;
    logic [31:0]      thr_q [NUM_THRESH];
    logic [31:0]      thr_sel;
    logic             accept;
    logic             thr_wr;

    assign accept    = (state_q == IDLE) && in_valid;
    assign thr_wr    = (state_q == IDLE) && thr_we;
    assign in_ready  = (state_q == IDLE);
    assign thr_busy  = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_index = idx_q;
    assign out_nan   = nan_q;

    // Select the threshold addressed by the scan pointer.
    always_comb begin
        thr_sel = POS_INF;
        for (int j = 0; j < NUM_THRESH; j++) begin
            if (i_q == IDX_W'(j)) begin
                thr_sel = thr_q[j];
            end
        end
    end

    // Next-state and result logic: accept, compare one entry per cycle, hold result.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        idx_d   = idx_q;
        nan_d   = nan_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    i_d   = '0;
                    idx_d = '0;
                    if (is_nan(in_data[30:0])) begin
                        nan_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        nan_d   = 1'b0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (thr_greater(x_q, thr_sel)) begin
                    idx_d   = i_q;
                    state_d = DONE;
                end else if (i_q == LAST_IDX) begin
                    idx_d   = FULL_IDX;
                    state_d = DONE;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            idx_q   <= '0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            idx_q   <= idx_d;
            nan_q   <= nan_d;
        end
    end

    // Input value latched on accept; only meaningful while scanning.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= in_data;
        end
    end

    // Threshold table: reset to +inf, written only in IDLE and only for valid addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_THRESH; j++) begin
                thr_q[j] <= POS_INF;
            end
        end else begin
            for (int j = 0; j < NUM_THRESH; j++) begin
                if (thr_wr && (thr_addr == IDX_W'(j))) begin
                    thr_q[j] <= thr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_bucket_index.sv
// Bench for fp_bucket_index: a default-size instance (15 thresholds) and a small
// instance (3 thresholds). Results are compared against a numeric float-ordering model.
module tb_fp_bucket_index;

    localparam int NA = 15;
    localparam int WA = 4;
    localparam int NB = 3;
    localparam int WB = 2;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [31:0] NINF = 32'hFF80_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          thr_we_a, thr_we_b;
    logic [3:0]    thr_addr;
    logic [31:0]   thr_data;
    logic          in_valid_a, in_valid_b;
    logic [31:0]   in_data;
    logic          out_ready;
    logic          busy_a, in_ready_a, out_valid_a, out_nan_a;
    logic [WA-1:0] out_index_a;
    logic          busy_b, in_ready_b, out_valid_b, out_nan_b;
    logic [WB-1:0] out_index_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [31:0] mthr_a [NA];
    logic [31:0] mthr_b [NB];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_bucket_index #(.NUM_THRESH(NA), .IDX_W(WA)) u_dut_a (
        .clk(clk), .reset(reset), .thr_we(thr_we_a), .thr_addr(thr_addr[WA-1:0]),
        .thr_data(thr_data), .thr_busy(busy_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_index(out_index_a), .out_nan(out_nan_a)
    );

    fp_bucket_index #(.NUM_THRESH(NB), .IDX_W(WB)) u_dut_b (
        .clk(clk), .reset(reset), .thr_we(thr_we_b), .thr_addr(thr_addr[WB-1:0]),
        .thr_data(thr_data), .thr_busy(busy_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_data(in_data), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_index(out_index_b), .out_nan(out_nan_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cur_valid(input int sel);
        return (sel == 0) ? 32'(out_valid_a) : 32'(out_valid_b);
    endfunction
    function automatic logic [31:0] cur_ready(input int sel);
        return (sel == 0) ? 32'(in_ready_a) : 32'(in_ready_b);
    endfunction
    function automatic logic [31:0] cur_busy(input int sel);
        return (sel == 0) ? 32'(busy_a) : 32'(busy_b);
    endfunction
    function automatic logic [31:0] cur_index(input int sel);
        return (sel == 0) ? 32'(out_index_a) : 32'(out_index_b);
    endfunction
    function automatic logic [31:0] cur_nan(input int sel);
        return (sel == 0) ? 32'(out_nan_a) : 32'(out_nan_b);
    endfunction

    // Reference: numeric IEEE-754 ordering from sign and magnitude.
    function automatic bit ref_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    // a < b as real numbers; false if either is NaN; +0 == -0.
    function automatic bit ref_less(input logic [31:0] a, input logic [31:0] b);
        if (ref_nan(a) || ref_nan(b)) return 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    task automatic ref_expect(input int sel, input logic [31:0] x,
                              output int idx, output int lat, output bit nan);
        int n;
        logic [31:0] t;
        n = (sel == 0) ? NA : NB;
        nan = ref_nan(x);
        idx = 0;
        lat = 1;
        if (!nan) begin
            idx = n;
            lat = n + 1;
            for (int i = 0; i < n; i++) begin
                t = (sel == 0) ? mthr_a[i] : mthr_b[i];
                if (ref_less(x, t)) begin
                    idx = i;
                    lat = i + 2;
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) mthr_a[i] = PINF;
        for (int i = 0; i < NB; i++) mthr_b[i] = PINF;
    endtask

    task automatic model_write(input int sel, input int addr, input logic [31:0] d);
        if (sel == 0 && addr < NA) mthr_a[addr] = d;
        if (sel == 1 && addr < NB) mthr_b[addr] = d;
    endtask

    // Threshold write while the instance is idle.
    task automatic write_thr(input int sel, input int addr, input logic [31:0] d);
        @(negedge clk);
        thr_addr = 4'(addr);
        thr_data = d;
        if (sel == 0) thr_we_a = 1'b1; else thr_we_b = 1'b1;
        @(posedge clk);
        #1;
        thr_we_a = 1'b0;
        thr_we_b = 1'b0;
        model_write(sel, addr, d);
    endtask

    // Present one input for one cycle; optionally write a threshold in the same cycle.
    task automatic start_input(input int sel, input logic [31:0] v, input bit wr,
                               input int waddr, input logic [31:0] wdata);
        @(negedge clk);
        chk("ready_before_accept", cur_ready(sel), 32'd1);
        in_data = v;
        if (sel == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
        if (wr) begin
            thr_addr = 4'(waddr);
            thr_data = wdata;
            if (sel == 0) thr_we_a = 1'b1; else thr_we_b = 1'b1;
            model_write(sel, waddr, wdata);
        end
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        thr_we_a   = 1'b0;
        thr_we_b   = 1'b0;
    endtask

    // Wait for the result, check it and its latency, optionally stall, then consume.
    task automatic finish_input(input int sel, input string tag, input logic [31:0] x, input int hold);
        int eidx, elat;
        bit enan;
        ref_expect(sel, x, eidx, elat, enan);
        while (cur_valid(sel) == 32'd0 && (cyc - acc_cyc) < 100) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid"}, cur_valid(sel), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(elat));
        chk({tag, "_index"}, cur_index(sel), 32'(eidx));
        chk({tag, "_nan"}, cur_nan(sel), 32'(enan));
        chk({tag, "_busy"}, cur_busy(sel), 32'd1);
        chk({tag, "_ready_low"}, cur_ready(sel), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, cur_valid(sel), 32'd1);
            chk({tag, "_hold_index"}, cur_index(sel), 32'(eidx));
            chk({tag, "_hold_nan"}, cur_nan(sel), 32'(enan));
            chk({tag, "_hold_ready"}, cur_ready(sel), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_consumed_valid"}, cur_valid(sel), 32'd0);
        chk({tag, "_consumed_ready"}, cur_ready(sel), 32'd1);
    endtask

    task automatic run_input(input int sel, input string tag, input logic [31:0] x, input int hold);
        start_input(sel, x, 1'b0, 0, 32'd0);
        finish_input(sel, tag, x, hold);
    endtask

    function automatic logic [31:0] rand_float(input int sel);
        logic [31:0] sp [8];
        logic [31:0] t;
        int c;
        sp = '{32'h0000_0000, 32'h8000_0000, PINF, NINF,
               32'h7FC0_0000, 32'h0000_0001, 32'h8000_0001, 32'h7F7F_FFFF};
        c = $urandom_range(0, 5);
        t = (sel == 0) ? mthr_a[$urandom_range(0, NA - 1)] : mthr_b[$urandom_range(0, NB - 1)];
        case (c)
            0: return $urandom();
            1: return {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)), 23'($urandom())};
            2: return sp[$urandom_range(0, 7)];
            3: return t;
            4: return ($urandom_range(0, 1) != 0) ? t + 32'd1 : t - 32'd1;
            default: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom())};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        thr_we_a   = 1'b0;
        thr_we_b   = 1'b0;
        thr_addr   = 4'd0;
        thr_data   = 32'd0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data    = 32'd0;
        out_ready  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_index", 32'(out_index_a), 32'd0);
        chk("rst_out_nan", 32'(out_nan_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);

        // Default table of +inf: every finite value maps to index 0.
        run_input(0, "rst_table_1p0", 32'h3F80_0000, 0);

        // Ascending table 1,2,3,4 then +inf.
        write_thr(0, 0, 32'h3F80_0000);
        write_thr(0, 1, 32'h4000_0000);
        write_thr(0, 2, 32'h4040_0000);
        write_thr(0, 3, 32'h4080_0000);
        run_input(0, "x2p5", 32'h4020_0000, 0);
        run_input(0, "x4p0", 32'h4080_0000, 0);
        run_input(0, "xneginf", NINF, 0);
        run_input(0, "xnan", 32'h7FC0_0000, 0);

        // Signed zero handling.
        write_thr(0, 0, 32'h0000_0000);
        write_thr(0, 1, PINF);
        write_thr(0, 2, PINF);
        write_thr(0, 3, PINF);
        run_input(0, "negzero_vs_poszero", 32'h8000_0000, 0);
        write_thr(0, 0, 32'h8000_0000);
        run_input(0, "poszero_vs_negzero", 32'h0000_0000, 0);

        // Stalled consumer.
        write_thr(0, 0, 32'h3F80_0000);
        write_thr(0, 1, 32'h4000_0000);
        write_thr(0, 2, 32'h4040_0000);
        write_thr(0, 3, 32'h4080_0000);
        run_input(0, "stall", 32'h4020_0000, 10);

        // Write during SCAN must be dropped.
        start_input(0, 32'h4080_0000, 1'b0, 0, 32'd0);
        chk("busy_in_scan", 32'(busy_a), 32'd1);
        thr_addr = 4'd0;
        thr_data = NINF;
        thr_we_a = 1'b1;
        @(posedge clk);
        #1;
        thr_we_a = 1'b0;
        finish_input(0, "busy_write_scan", 32'h4080_0000, 0);
        run_input(0, "busy_write_followup", 32'h3F00_0000, 0);

        // Write in the accept cycle is seen by the scan.
        start_input(0, 32'h40A0_0000, 1'b1, 0, 32'h4120_0000);
        finish_input(0, "write_with_accept", 32'h40A0_0000, 0);

        // Out-of-range address on the full-size instance is ignored.
        write_thr(0, 15, NINF);
        run_input(0, "oob_write", 32'h3F00_0000, 0);

        // Small instance: all thresholds 0.5.
        for (int i = 0; i < NB; i++) write_thr(1, i, 32'h3F00_0000);
        run_input(1, "small_7p0", 32'h40E0_0000, 2);

        // Reset during SCAN loses the result and restores +inf thresholds.
        start_input(1, 32'h40E0_0000, 1'b0, 0, 32'd0);
        chk("small_busy_scan", 32'(busy_b), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midscan_rst_valid", 32'(out_valid_b), 32'd0);
        chk("midscan_rst_busy", 32'(busy_b), 32'd0);
        chk("midscan_rst_index", 32'(out_index_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_input(1, "small_after_rst", 32'h3F80_0000, 0);
        run_input(0, "big_after_rst", 32'h3F80_0000, 0);

        // Randomized tables and inputs.
        for (int r = 0; r < 30; r++) begin
            for (int a = 0; a < NA; a++) write_thr(0, a, rand_float(0));
            if ($urandom_range(0, 3) == 0) write_thr(0, 15, rand_float(0));
            for (int k = 0; k < 8; k++) run_input(0, "rand_a", rand_float(0), $urandom_range(0, 2));
        end
        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < NB; a++) write_thr(1, a, rand_float(1));
            write_thr(1, 3, rand_float(1));
            for (int k = 0; k < 6; k++) run_input(1, "rand_b", rand_float(1), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_bucket_index.md
# fp_bucket_index

Sequential IEEE-754 single-precision bucketiser: compares one input value against a programmable table of up to NUM_THRESH thresholds and returns the bucket index, i.e. the position of the first threshold strictly greater than the input. It is the parametrised successor of the fixed-count float comparison index logic in the play_gif datapath. Threshold count and index width are generics, thresholds are runtime-loadable, and it has valid/ready handshakes and explicit NaN/signed-zero handling. It sits between the pixel/frame float datapath and the palette/LUT index consumers.

## Interface
- NUM_THRESH, 15, number of threshold registers (1..255).
- IDX_W, 4, width of index and threshold address; requires 2^IDX_W > NUM_THRESH.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- thr_we  in  1  threshold write strobe.
- thr_addr  in  IDX_W  threshold register address.
- thr_data  in  32  IEEE-754 threshold value.
- thr_busy  out  1  high when state is not IDLE; writes ignored while high.
- in_valid  in  1  input value valid.
- in_ready  out  1  block can accept input (high only in IDLE).
- in_data  in  32  IEEE-754 input value.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- out_index  out  IDX_W  bucket index 0..NUM_THRESH.
- out_nan  out  1  input was NaN (out_index forced to 0).

## Operation
- Ordering key: canonicalise ±0 to +0 (if bits[30:0]==0, use 0). key = sign ? ~f : f ^ 32'h8000_0000. x<t is unsigned key(x)<key(t). NaN thresholds are never greater than x, so they are skipped.
- Threshold write: when thr_we && state==IDLE && thr_addr<NUM_THRESH, thr[thr_addr] is updated at the clock edge. Writes in any other case are dropped silently.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid, latch in_data and set i=0.
  - If the input is NaN (exp all ones, mantissa≠0): out_index=0, out_nan=1, go to DONE.
  - Otherwise go to SCAN.
- SCAN: one compare per cycle.
  - If key(x)<key(thr[i]): out_index=i, go to DONE.
  - Else if i==NUM_THRESH-1: out_index=NUM_THRESH, go to DONE.
  - Else i=i+1.
- DONE: out_valid=1; out_index and out_nan stable. On out_ready, go to IDLE.
- The result does not depend on table ordering: it is always the first i in ascending address order. For a nondecreasing table this equals the count of thresholds <= x.
- Infinities and denormals are ordered naturally by key. +inf input with a full finite table gives NUM_THRESH.

## Timing
- Reset values: state IDLE, in_ready=1 once reset deasserts, out_valid=0, out_index=0, out_nan=0, thr_busy=0, i=0. All thr[] reset to +inf (32'h7F80_0000), so every non-NaN finite input maps to index 0.
- Latency from the accept edge to out_valid=1 is k+1 cycles, where k = number of compares (1..NUM_THRESH). NaN input: 1 cycle.
- in_ready is low from the cycle after accept until the cycle after the out_valid&&out_ready handshake. Back-to-back accepts are separated by at least k+2 cycles.
- out_valid holds indefinitely under out_ready=0, with stable data.
- Asserting reset mid-SCAN or in DONE immediately forces the reset values and restores thr[] to +inf. The pending result is lost.
- thr_we in the same cycle as an input accept in IDLE is performed. The scan starts the next cycle and sees the new value.

## Test plan
- Reset, no writes; input 1.0 (32'h3F80_0000) -> out_index=0, out_nan=0, out_valid 2 cycles after accept.
- Load thr[0..3]=1.0,2.0,3.0,4.0 and the rest +inf; input 2.5 -> out_index=2, out_valid 4 cycles after accept. Input 4.0 -> index 4. Input -inf -> index 0.
- NaN input 32'h7FC0_0000 -> out_nan=1, out_index=0, out_valid 1 cycle after accept.
- thr[0]=+0.0, thr[1..]=+inf; input -0.0 (32'h8000_0000) -> index 1. With thr[0]=-0.0, input +0.0 -> index 1.
- Hold out_ready=0 for 10 cycles -> out_valid/out_index stable and in_ready=0. Issue thr_we to addr 0 during SCAN -> table unchanged, verified by a follow-up input.
- With NUM_THRESH=3, IDX_W=2, all thresholds 0.5; input 7.0 -> index 3 after 3 compares. Assert reset during SCAN -> out_valid=0, next input 1.0 -> index 0.
